// File: rtl/mmio_uart_tx_if.sv
// CPU data-side bus slice seen by the memory-mapped UART transmitter.
// The CPU drives store strobe, address and data; the peripheral returns read data and a select.
interface mmio_uart_tx_if;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        sel;

   modport master (output memwrite, dataadr, writedata, input readdata, sel);
   modport slave  (input memwrite, dataadr, writedata, output readdata, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window, small TX FIFO,
// and a serialiser FSM with a single baud counter.
//
// state   | meaning
// S_IDLE  | line high; pops the FIFO head when one is waiting
// S_START | start bit (low) for CLKS_PER_BIT cycles
// S_DATA  | eight data bits, LSB first, CLKS_PER_BIT cycles each
// S_STOP  | stop bit (high) for CLKS_PER_BIT cycles
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic             clk,
   input  logic             reset,
   mmio_uart_tx_if.slave    bus,
   output logic             tx,
   output logic             busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            busy_q, busy_d;

   logic [7:0]      fifo_q [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q, count_d;
   logic            ovf_q;

   logic            hit_data, hit_stat, push_req, clr_req;
   logic            full, empty, pop, accept, baud_last;
   logic [3:0]      count4;
   logic            unused_wdata;

   assign hit_data  = (bus.dataadr == BASE_ADDR);
   assign hit_stat  = (bus.dataadr == BASE_ADDR + 32'd4);
   assign push_req  = bus.memwrite && hit_data;
   assign clr_req   = bus.memwrite && hit_stat && bus.writedata[3];
   assign full      = (count_q == CW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   // A pop on the same edge frees the slot the push lands in.
   assign accept    = push_req && (!full || pop);
   assign count_d   = count_q + CW'(accept) - CW'(pop);
   assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
   assign count4    = 4'(count_q);
   assign unused_wdata = ^bus.writedata[31:8];

   assign bus.sel      = hit_data || hit_stat;
   assign bus.readdata = hit_stat ? {24'b0, count4, ovf_q, (state_q != S_IDLE), empty, full}
                                  : 32'b0;
   assign tx   = tx_q;
   assign busy = busy_q;

   always_ff @(posedge clk) begin
      if (accept) fifo_q[wr_ptr_q] <= bus.writedata[7:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         if (accept) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)    rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push_req && !accept) ovf_q <= 1'b1;
         else if (clr_req)        ovf_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_q[rd_ptr_q];
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               baud_d  = '0;
               bit_d   = '0;
               state_d = S_DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_DATA: begin
            if (baud_last) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               if (bit_q == 3'd7) state_d = S_STOP;
               else               bit_d   = bit_q + 3'd1;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         S_STOP: begin
            if (baud_last) begin
               baud_d  = '0;
               state_d = S_IDLE;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered outputs are computed from the next state so they line up with it.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (count_d != '0) || (state_d != S_IDLE);
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4: a line
// decoder turns tx back into bytes, and expectations come from byte queues and the register map.
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE = 32'hFFFF_0000;
   localparam logic [31:0] STAT = 32'hFFFF_0004;
   localparam int          CPB  = 4;

   logic clk, reset, tx, busy;
   int   n_cmp, n_err, cyc;

   logic [7:0] rx_q[$];
   int         rx_t[$];
   int         rx_err;

   mmio_uart_tx_if bus ();

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .bus(bus.slave), .tx(tx), .busy(busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Line decoder: centre-samples an 8N1 frame; a frame disturbed by reset is discarded.
   initial begin
      logic [7:0] b;
      int t0;
      bit ok, abort;
      forever begin
         @(negedge clk);
         if (!reset && tx === 1'b0) begin
            t0 = cyc; ok = 1; abort = 0; b = '0;
            repeat (2) begin @(negedge clk); if (reset) abort = 1; end
            if (tx !== 1'b0) ok = 0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) begin @(negedge clk); if (reset) abort = 1; end
               b[i] = tx;
            end
            repeat (CPB) begin @(negedge clk); if (reset) abort = 1; end
            if (tx !== 1'b1) ok = 0;
            if (!abort) begin
               rx_q.push_back(b);
               rx_t.push_back(t0);
               if (!ok) rx_err++;
            end
         end
      end
   end

   function automatic logic [31:0] status_word(int count, bit ovf, bit active);
      logic [3:0] c;
      c = 4'(count);
      return {24'b0, c, ovf, active, (count == 0), (count == 4)};
   endfunction

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      bus.memwrite = 1'b1; bus.dataadr = a; bus.writedata = d;
      @(negedge clk);
      bus.memwrite = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic s);
      bus.dataadr = a;
      #1;
      d = bus.readdata;
      s = bus.sel;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < max_cyc) begin @(negedge clk); n++; end
      if (busy !== 1'b0) begin
         n_cmp++; n_err++;
         $display("FAIL wait_idle: busy still %b after %0d cycles, expected 0", busy, max_cyc);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic check_rx(input string name, input logic [7:0] exp_q[$]);
      n_cmp++;
      if (rx_q.size() !== exp_q.size()) begin
         n_err++;
         $display("FAIL %s count: got %0d bytes, expected %0d", name, rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL %s byte%0d: got %h expected %h", name, i, rx_q[i], exp_q[i]);
            end
         end
      end
      n_cmp++;
      if (rx_err !== 0) begin
         n_err++;
         $display("FAIL %s framing: got %0d bad frames expected 0", name, rx_err);
      end
   endtask

   task automatic clear_rx();
      rx_q.delete(); rx_t.delete(); rx_err = 0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic s; int changes; logic prev;
      rd(STAT, d, s);
      n_cmp++; if (d !== 32'h2 || s !== 1'b1) begin n_err++; $display("FAIL por_status: got %h sel %b expected 00000002 sel 1", d, s); end
      n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL por_lines: got tx %b busy %b expected 1 0", tx, busy); end
      clear_rx();
      sw(BASE, 32'hA5);
      repeat (10) @(negedge clk);   // inside data bit 1 of 0xA5, which is 0
      n_cmp++; if (tx !== 1'b0) begin n_err++; $display("FAIL mid_frame_tx: got %b expected 0", tx); end
      reset = 1'b1;
      #1;
      n_cmp++; if (tx !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset: got tx %b busy %b expected 1 0", tx, busy); end
      rd(STAT, d, s);
      n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL reset_status: got %h expected 00000002", d); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      changes = 0; prev = tx;
      repeat (60) begin @(negedge clk); if (tx !== prev) changes++; prev = tx; end
      n_cmp++; if (changes !== 0 || tx !== 1'b1) begin n_err++; $display("FAIL post_reset_quiet: got %0d transitions tx %b expected 0 transitions tx 1", changes, tx); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
      n_cmp++; if (rx_q.size() !== 0) begin n_err++; $display("FAIL aborted_frame: got %0d bytes expected 0", rx_q.size()); end
   endtask

   task automatic test_single_frame();
      logic [7:0] b; logic exp; int bad;
      b = 8'h55; bad = 0;
      clear_rx();
      sw(BASE, {24'b0, b});
      n_cmp++; if (tx !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL push_edge: got tx %b busy %b expected 1 1", tx, busy); end
      for (int k = 0; k < 10 * CPB; k++) begin
         @(negedge clk);
         if (k < CPB)           exp = 1'b0;
         else if (k < 9 * CPB)  exp = b[(k - CPB) / CPB];
         else                   exp = 1'b1;
         n_cmp++;
         if (tx !== exp) begin n_err++; bad++; if (bad < 4) $display("FAIL wave_k%0d: got tx %b expected %b", k, tx, exp); end
      end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_last_stop: got %b expected 1", busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0 || tx !== 1'b1) begin n_err++; $display("FAIL frame_end: got busy %b tx %b expected 0 1", busy, tx); end
      check_rx("single", '{8'h55});
   endtask

   task automatic test_back_to_back();
      logic [31:0] d; logic s; logic tx_after1;
      clear_rx();
      sw(BASE, 32'h01);
      tx_after1 = tx;
      sw(BASE, 32'h02);
      n_cmp++; if (tx_after1 !== 1'b1 || tx !== 1'b0) begin n_err++; $display("FAIL latency: got tx %b then %b expected 1 then 0", tx_after1, tx); end
      sw(BASE, 32'h03);
      sw(BASE, 32'h04);
      sw(BASE, 32'h05);
      rd(STAT, d, s);
      n_cmp++; if (d !== status_word(4, 0, 1)) begin n_err++; $display("FAIL burst_full_status: got %h expected %h", d, status_word(4, 0, 1)); end
      wait_idle(400);
      check_rx("burst", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
      for (int i = 1; i < rx_t.size(); i++) begin
         n_cmp++;
         if (rx_t[i] - rx_t[i-1] !== 10 * CPB + 1) begin n_err++; $display("FAIL gap%0d: got %0d cycles expected %0d", i, rx_t[i] - rx_t[i-1], 10 * CPB + 1); end
      end
      rd(STAT, d, s);
      n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL burst_idle_status: got %h expected 00000002", d); end
   endtask

   task automatic test_overflow();
      logic [31:0] d; logic s;
      clear_rx();
      for (int i = 0; i < 5; i++) sw(BASE, 32'h10 + i);
      sw(BASE, 32'h99);
      rd(STAT, d, s);
      n_cmp++; if (d !== status_word(4, 1, 1)) begin n_err++; $display("FAIL ovf_set: got %h expected %h", d, status_word(4, 1, 1)); end
      sw(STAT, 32'hF7);
      rd(STAT, d, s);
      n_cmp++; if (d !== status_word(4, 1, 1)) begin n_err++; $display("FAIL ovf_no_clear: got %h expected %h", d, status_word(4, 1, 1)); end
      sw(STAT, 32'h8);
      rd(STAT, d, s);
      n_cmp++; if (d !== status_word(4, 0, 1)) begin n_err++; $display("FAIL ovf_clear: got %h expected %h", d, status_word(4, 0, 1)); end
      wait_idle(400);
      check_rx("overflow", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});
   endtask

   task automatic test_decode();
      logic [31:0] d; logic s; int changes;
      rd(STAT, d, s);
      n_cmp++; if (d !== 32'h2 || s !== 1'b1) begin n_err++; $display("FAIL lw_status: got %h sel %b expected 00000002 sel 1", d, s); end
      rd(BASE, d, s);
      n_cmp++; if (d !== 32'h0 || s !== 1'b1) begin n_err++; $display("FAIL lw_txdata: got %h sel %b expected 00000000 sel 1", d, s); end
      rd(32'h1001_0000, d, s);
      n_cmp++; if (d !== 32'h0 || s !== 1'b0) begin n_err++; $display("FAIL lw_other: got %h sel %b expected 00000000 sel 0", d, s); end
      rd(32'hFFFF_0002, d, s);
      n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL sel_unaligned: got %b expected 0", s); end
      sw(32'hFFFF_0002, 32'h5A);
      changes = 0;
      repeat (10) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) changes++; end
      rd(STAT, d, s);
      n_cmp++; if (d !== 32'h2 || changes !== 0) begin n_err++; $display("FAIL unaligned_push: got status %h activity %0d expected 00000002 activity 0", d, changes); end
   endtask

   task automatic test_push_pop_same_edge();
      logic [31:0] d; logic s; int n;
      clear_rx();
      for (int i = 0; i < 5; i++) sw(BASE, 32'h20 + i);
      n = 0;
      rd(STAT, d, s);
      while (d[2] !== 1'b0 && n < 200) begin @(negedge clk); rd(STAT, d, s); n++; end
      n_cmp++; if (d !== status_word(4, 0, 0)) begin n_err++; $display("FAIL idle_full_status: got %h expected %h", d, status_word(4, 0, 0)); end
      sw(BASE, 32'h77);
      rd(STAT, d, s);
      n_cmp++; if (d !== status_word(4, 0, 1)) begin n_err++; $display("FAIL push_pop_status: got %h expected %h", d, status_word(4, 0, 1)); end
      wait_idle(400);
      check_rx("push_pop", '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h77});
   endtask

   task automatic test_random();
      logic [7:0] exp_q[$]; logic [7:0] b; logic [31:0] d; logic s; int n;
      for (int r = 0; r < 4; r++) begin
         clear_rx();
         exp_q.delete();
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            sw(BASE, {$urandom, b} >> 0 & 32'hFFFF_FFFF);
            repeat ($urandom_range(0, 3)) @(negedge clk);
         end
         wait_idle(500);
         check_rx("random", exp_q);
         rd(STAT, d, s);
         n_cmp++; if (d !== 32'h2) begin n_err++; $display("FAIL random_status: got %h expected 00000002", d); end
      end
   endtask

   initial begin
      n_cmp = 0; n_err = 0; cyc = 0; rx_err = 0;
      reset = 1'b1;
      bus.memwrite = 1'b0; bus.dataadr = 32'h0; bus.writedata = 32'h0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_overflow();
      test_decode();
      test_push_pop_same_edge();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
